// File: rtl/dda_uart_host.sv
// Initiator end of the DDA UART link: sends the 10-byte config frame, collects the 5-byte state reply.
// Optional reply-gap timeout is enabled with `define DDA_UART_HOST_TIMEOUT_EN.
module dda_uart_host #(
    parameter int unsigned N           = 16,
    parameter int unsigned CFG_BYTES   = 10,
    parameter int unsigned RESP_BYTES  = 5,
    parameter int unsigned TIMEOUT_CYC = 5000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] ic1,
    input  logic [N-1:0] ic2,
    input  logic [N-1:0] vK_M,
    input  logic [N-1:0] vD_M,
    input  logic [N-1:0] dt,
    output logic         busy,
    output logic [N-1:0] v1,
    output logic [N-1:0] v2,
    output logic         state_valid,
    output logic         err,
    output logic         uart_transmit,
    output logic [7:0]   uart_tx_byte,
    input  logic         uart_is_transmitting,
    input  logic         uart_received,
    input  logic [7:0]   uart_rx_byte,
    input  logic         uart_recv_error
);

    localparam int unsigned FRAME_W = CFG_BYTES * 8;
    localparam int unsigned TX_W    = $clog2(CFG_BYTES);
    localparam int unsigned RX_W    = $clog2(RESP_BYTES);
    localparam int unsigned ST_W    = 2 * N;
`ifdef DDA_UART_HOST_TIMEOUT_EN
    localparam int unsigned CNT_W   = $clog2(TIMEOUT_CYC);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_REQ,
        S_TX_WAIT,
        S_RX,
        S_DONE
    } state_t;

    state_t            state;
    logic [FRAME_W-1:0] frame_q;
    logic [TX_W-1:0]   tx_idx;
    logic [RX_W-1:0]   rx_idx;
    logic [ST_W-1:0]   rx_shift;
    logic              seen_high;
`ifdef DDA_UART_HOST_TIMEOUT_EN
    logic [CNT_W-1:0]  to_cnt;
`endif

    // Frame is shifted out MSB-first, so the next byte to send is always the top byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            frame_q       <= '0;
            tx_idx        <= '0;
            rx_idx        <= '0;
            rx_shift      <= '0;
            seen_high     <= 1'b0;
            busy          <= 1'b0;
            v1            <= '0;
            v2            <= '0;
            state_valid   <= 1'b0;
            err           <= 1'b0;
            uart_transmit <= 1'b0;
            uart_tx_byte  <= '0;
`ifdef DDA_UART_HOST_TIMEOUT_EN
            to_cnt        <= '0;
`endif
        end else begin
            uart_transmit <= 1'b0;
            state_valid   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        frame_q <= FRAME_W'({ic1, ic2, vK_M, vD_M, dt});
                        err     <= 1'b0;
                        tx_idx  <= '0;
                        rx_idx  <= '0;
                        busy    <= 1'b1;
                        state   <= S_TX_REQ;
                    end
                end
                S_TX_REQ: begin
                    if (!uart_is_transmitting) begin
                        uart_tx_byte  <= frame_q[FRAME_W-1 -: 8];
                        uart_transmit <= 1'b1;
                        seen_high     <= 1'b0;
                        state         <= S_TX_WAIT;
                    end
                end
                S_TX_WAIT: begin
                    // A byte is complete only after the uart has been seen busy and then idle.
                    if (uart_is_transmitting) begin
                        seen_high <= 1'b1;
                    end else if (seen_high) begin
                        seen_high <= 1'b0;
                        frame_q   <= frame_q << 8;
                        if (tx_idx == TX_W'(CFG_BYTES - 1)) begin
                            rx_idx <= '0;
`ifdef DDA_UART_HOST_TIMEOUT_EN
                            to_cnt <= '0;
`endif
                            state  <= S_RX;
                        end else begin
                            tx_idx <= tx_idx + 1'b1;
                            state  <= S_TX_REQ;
                        end
                    end
                end
                S_RX: begin
                    if (uart_recv_error) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (uart_received) begin
`ifdef DDA_UART_HOST_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                        if (rx_idx == RX_W'(RESP_BYTES - 1)) begin
                            // Trailing pad byte: publish the state on the same edge DONE is entered.
                            v1          <= rx_shift[ST_W-1 -: N];
                            v2          <= rx_shift[N-1:0];
                            state_valid <= 1'b1;
                            busy        <= 1'b0;
                            state       <= S_DONE;
                        end else begin
                            rx_shift <= {rx_shift[ST_W-9:0], uart_rx_byte};
                            rx_idx   <= rx_idx + 1'b1;
                        end
                    end
`ifdef DDA_UART_HOST_TIMEOUT_EN
                    else if (to_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dda_uart_host.sv
// Scoreboard bench for dda_uart_host: behavioural uart model, expected tx bytes and state words queued at stimulus time.
module tb_dda_uart_host;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] ic1, ic2, vK_M, vD_M, dt;
    logic        busy;
    logic [15:0] v1, v2;
    logic        state_valid;
    logic        err;
    logic        uart_transmit;
    logic [7:0]  uart_tx_byte;
    logic        uart_is_transmitting;
    logic        uart_received;
    logic [7:0]  uart_rx_byte;
    logic        uart_recv_error;

    int          checks = 0;
    int          errors = 0;
    int          tx_count = 0;
    int          sv_count = 0;
    int          hold_cyc = 4;
    int          overlap_cnt = 0;
    logic [7:0]  tx_exp[$];
    logic [31:0] sv_exp[$];
    logic [15:0] last_v1 = 16'h0;
    logic [15:0] last_v2 = 16'h0;

    always #5 clk = ~clk;

    dda_uart_host #(.TIMEOUT_CYC(100)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .ic1                 (ic1),
        .ic2                 (ic2),
        .vK_M                (vK_M),
        .vD_M                (vD_M),
        .dt                  (dt),
        .busy                (busy),
        .v1                  (v1),
        .v2                  (v2),
        .state_valid         (state_valid),
        .err                 (err),
        .uart_transmit       (uart_transmit),
        .uart_tx_byte        (uart_tx_byte),
        .uart_is_transmitting(uart_is_transmitting),
        .uart_received       (uart_received),
        .uart_rx_byte        (uart_rx_byte),
        .uart_recv_error     (uart_recv_error)
    );

    // uart TX model: goes busy for hold_cyc cycles after each request, flags any request while busy
    initial begin
        uart_is_transmitting = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_transmit) begin
                uart_is_transmitting = 1'b1;
                for (int k = 0; k < hold_cyc; k++) begin
                    @(negedge clk);
                    if (uart_transmit) overlap_cnt++;
                end
                uart_is_transmitting = 1'b0;
            end
        end
    end

    // scoreboard: compare every transmit byte and every state_valid against queued expectations
    initial begin
        logic [7:0]  e8;
        logic [31:0] e32;
        forever begin
            @(negedge clk);
            if (uart_transmit) begin
                tx_count++;
                checks++;
                if (tx_exp.size() == 0) begin
                    errors++;
                    $display("FAIL tx_byte: got %02h, required no transmit", uart_tx_byte);
                end else begin
                    e8 = tx_exp.pop_front();
                    if (uart_tx_byte !== e8) begin
                        errors++;
                        $display("FAIL tx_byte: got %02h, required %02h", uart_tx_byte, e8);
                    end
                end
            end
            if (state_valid) begin
                sv_count++;
                checks++;
                if (sv_exp.size() == 0) begin
                    errors++;
                    $display("FAIL state_valid: got v1=%04h v2=%04h, required no strobe", v1, v2);
                end else begin
                    e32 = sv_exp.pop_front();
                    if ({v1, v2} !== e32) begin
                        errors++;
                        $display("FAIL state_word: got %08h, required %08h", {v1, v2}, e32);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                            input logic [15:0] d, input logic [15:0] e, input bit expect_frame);
        @(negedge clk);
        ic1 = a; ic2 = b; vK_M = c; vD_M = d; dt = e;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (expect_frame) begin
            tx_exp.push_back(a[15:8]); tx_exp.push_back(a[7:0]);
            tx_exp.push_back(b[15:8]); tx_exp.push_back(b[7:0]);
            tx_exp.push_back(c[15:8]); tx_exp.push_back(c[7:0]);
            tx_exp.push_back(d[15:8]); tx_exp.push_back(d[7:0]);
            tx_exp.push_back(e[15:8]); tx_exp.push_back(e[7:0]);
        end
    endtask

    task automatic wait_tx(input int target, input bit need_idle, input string tag);
        int n = 0;
        while (!(tx_count >= target && (!need_idle || !uart_is_transmitting)) && n < 40000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 40000) begin
            checks++;
            errors++;
            $display("FAIL %s_wait: tx_count=%0d, required %0d", tag, tx_count, target);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit with_err);
        @(negedge clk);
        uart_rx_byte    = b;
        uart_received   = 1'b1;
        uart_recv_error = with_err;
        @(negedge clk);
        uart_received   = 1'b0;
        uart_recv_error = 1'b0;
    endtask

    task automatic send_reply(input logic [39:0] r);
        for (int i = 0; i < 5; i++) begin
            send_byte(r[39-8*i -: 8], 1'b0);
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, state_valid, err, uart_transmit, uart_tx_byte, v1, v2} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b sv=%b err=%b tx=%b byte=%02h v1=%04h v2=%04h, required all 0",
                     busy, state_valid, err, uart_transmit, uart_tx_byte, v1, v2);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (tx_count !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got tx_count=%0d busy=%b, required 0 0", tx_count, busy);
        end
    endtask

    task automatic test_basic;
        int tx0 = tx_count;
        int sv0 = sv_count;
        hold_cyc = 4;
        do_start(16'h4000, 16'h0000, 16'h3800, 16'h3000, 16'h2000, 1'b1);
        sv_exp.push_back({16'h4000, 16'h3C00});
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_set: got %b, required 1", busy);
        end
        wait_tx(tx0 + 10, 1'b1, "basic");
        checks++;
        if (tx_count - tx0 !== 10 || tx_exp.size() !== 0) begin
            errors++;
            $display("FAIL basic_tx_count: got %0d pulses, %0d pending, required 10 and 0", tx_count - tx0, tx_exp.size());
        end
        send_reply(40'h40_00_3C_00_A5);
        repeat (3) @(negedge clk);
        checks++;
        if (sv_count - sv0 !== 1 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: got strobes=%0d busy=%b err=%b, required 1 0 0", sv_count - sv0, busy, err);
        end
        last_v1 = 16'h4000;
        last_v2 = 16'h3C00;
    endtask

    task automatic test_throttle;
        int tx0 = tx_count;
        int sv0 = sv_count;
        hold_cyc    = 3000;
        overlap_cnt = 0;
        do_start(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F1E, 1'b1);
        sv_exp.push_back({16'hBEEF, 16'h0102});
        wait_tx(tx0 + 10, 1'b1, "throttle");
        checks++;
        if (overlap_cnt !== 0) begin
            errors++;
            $display("FAIL throttle_overlap: got %0d requests while uart busy, required 0", overlap_cnt);
        end
        checks++;
        if (tx_exp.size() !== 0) begin
            errors++;
            $display("FAIL throttle_pending: got %0d bytes unsent, required 0", tx_exp.size());
        end
        send_reply(40'hBE_EF_01_02_00);
        repeat (3) @(negedge clk);
        checks++;
        if (sv_count - sv0 !== 1) begin
            errors++;
            $display("FAIL throttle_strobe: got %0d, required 1", sv_count - sv0);
        end
        last_v1  = 16'hBEEF;
        last_v2  = 16'h0102;
        hold_cyc = 4;
    endtask

    task automatic test_back_to_back;
        int tx0 = tx_count;
        int sv0 = sv_count;
        hold_cyc = 6;
        do_start(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 1'b1);
        sv_exp.push_back({16'h7766, 16'h5544});
        wait_tx(tx0 + 3, 1'b0, "b2b_mid");
        do_start(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE, 1'b0);
        checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy: got busy=%b err=%b, required 1 0", busy, err);
        end
        wait_tx(tx0 + 10, 1'b1, "b2b");
        checks++;
        if (tx_exp.size() !== 0 || tx_count - tx0 !== 10) begin
            errors++;
            $display("FAIL b2b_frame: got %0d pulses, %0d pending, required 10 and 0", tx_count - tx0, tx_exp.size());
        end
        send_reply(40'h77_66_55_44_33);
        repeat (3) @(negedge clk);
        checks++;
        if (sv_count - sv0 !== 1) begin
            errors++;
            $display("FAIL b2b_strobe: got %0d, required 1", sv_count - sv0);
        end
        last_v1  = 16'h7766;
        last_v2  = 16'h5544;
        hold_cyc = 4;
    endtask

    task automatic test_recv_error;
        int tx0 = tx_count;
        int sv0 = sv_count;
        do_start(16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 1'b1);
        wait_tx(tx0 + 10, 1'b1, "rxerr");
        send_byte(8'h11, 1'b0);
        repeat (2) @(negedge clk);
        send_byte(8'h22, 1'b0);
        repeat (2) @(negedge clk);
        // error coincides with a third byte: the byte must be dropped
        send_byte(8'h33, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rxerr_flags: got err=%b busy=%b, required 1 0", err, busy);
        end
        checks++;
        if (sv_count !== sv0 || v1 !== last_v1 || v2 !== last_v2) begin
            errors++;
            $display("FAIL rxerr_hold: got strobes=%0d v1=%04h v2=%04h, required %0d %04h %04h",
                     sv_count - sv0, v1, v2, 0, last_v1, last_v2);
        end
        tx0 = tx_count;
        do_start(16'hCAFE, 16'hF00D, 16'h0001, 16'h8000, 16'h7FFF, 1'b1);
        sv_exp.push_back({16'hFFFF, 16'h0000});
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rxerr_clear: got err=%b busy=%b, required 0 1", err, busy);
        end
        wait_tx(tx0 + 10, 1'b1, "rxerr2");
        send_reply(40'hFF_FF_00_00_5A);
        repeat (3) @(negedge clk);
        checks++;
        if (sv_count - sv0 !== 1 || err !== 1'b0) begin
            errors++;
            $display("FAIL rxerr_recover: got strobes=%0d err=%b, required 1 0", sv_count - sv0, err);
        end
        last_v1 = 16'hFFFF;
        last_v2 = 16'h0000;
    endtask

    task automatic test_reset_mid;
        int tx0 = tx_count;
        int tx_at_rst;
        int n = 0;
        hold_cyc = 8;
        do_start(16'h1357, 16'h2468, 16'h9BDF, 16'hACE0, 16'h4321, 1'b1);
        wait_tx(tx0 + 5, 1'b0, "rstmid");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tx_at_rst = tx_count;
        checks++;
        if ({busy, state_valid, err, uart_transmit, uart_tx_byte, v1, v2} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got busy=%b sv=%b err=%b tx=%b byte=%02h v1=%04h v2=%04h, required all 0",
                     busy, state_valid, err, uart_transmit, uart_tx_byte, v1, v2);
        end
        tx_exp.delete();
        last_v1 = 16'h0;
        last_v2 = 16'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        while (uart_is_transmitting && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (50) @(negedge clk);
        checks++;
        if (tx_count !== tx_at_rst || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_quiet: got %0d extra pulses busy=%b, required 0 0", tx_count - tx_at_rst, busy);
        end
        hold_cyc = 4;
    endtask

    task automatic test_timeout;
        int tx0 = tx_count;
        int sv0 = sv_count;
        do_start(16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00, 16'h5555, 1'b1);
        wait_tx(tx0 + 10, 1'b1, "timeout");
        send_byte(8'h01, 1'b0);
        repeat (2) @(negedge clk);
        send_byte(8'h02, 1'b0);
`ifdef DDA_UART_HOST_TIMEOUT_EN
        repeat (99) @(negedge clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: got err=%b busy=%b at 99 cycles, required 0 1", err, busy);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fire: got err=%b busy=%b at 100 cycles, required 1 0", err, busy);
        end
`else
        repeat (10000) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_none: got busy=%b err=%b after 10000 cycles, required 1 0", busy, err);
        end
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (sv_count !== sv0 || tx_exp.size() !== 0) begin
            errors++;
            $display("FAIL timeout_nostrobe: got strobes=%0d pending=%0d, required 0 0", sv_count - sv0, tx_exp.size());
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        start           = 1'b0;
        ic1             = '0;
        ic2             = '0;
        vK_M            = '0;
        vD_M            = '0;
        dt              = '0;
        uart_received   = 1'b0;
        uart_rx_byte    = '0;
        uart_recv_error = 1'b0;

        test_reset();
        test_basic();
        test_throttle();
        test_back_to_back();
        test_recv_error();
        test_reset_mid();
        test_timeout();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
